edge_irq_arbiter: RTL and testbench

Multi-channel edge-triggered interrupt controller. Each asynchronous input is synchronized and edge-detected (rising, falling or both, per channel), and the detected events are latched as pending flags. A round-robin arbiter presents one pending channel at a time to a single consumer over a valid/ack handshake. It sits between raw external request lines and the host-side interrupt service logic, and replaces per-line standalone edge detectors.

---
 rtl/edge_irq_arbiter.sv | 139 +++++++++++++
 tb/tb_edge_irq_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_irq_arbiter.sv
// Edge-triggered interrupt controller: per-channel synchronizer and edge detect,
// sticky pending/overrun flags, and a round-robin valid/ack grant to one consumer.
module edge_irq_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   irq_in,
  input  logic [2*N-1:0] mode_cfg,
  input  logic           clr_all,
  input  logic           irq_ack,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  logic [N-1:0]   s0, s1, s2;
  logic [N-1:0]   rise, fall, ev, ack_clr;
  logic [N-1:0]   pending_q, overrun_q;
  logic           ack_fire;
  state_t         state_q, state_d;
  logic           irq_valid_q, irq_valid_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] sel, cand;
  logic           found;

  // Synchronizer chain; never touched by clr_all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      s0 <= irq_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  for (genvar i = 0; i < N; i++) begin : g_event
    assign ev[i] = (mode_cfg[2*i] & rise[i]) | (mode_cfg[2*i+1] & fall[i]);
  end

  assign ack_fire = irq_valid_q & irq_ack;

  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[irq_id_q] = 1'b1;
  end

  // A new event on the channel being acked keeps its pending bit and is not an overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else if (clr_all) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_clr) | ev;
      overrun_q <= overrun_q | (ev & pending_q & ~ack_clr);
    end
  end

  // Round-robin pick: first pending bit above last_grant, wrapping
  always_comb begin
    found = 1'b0;
    sel   = last_grant_q;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % N);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irq_valid_q  <= 1'b0;
      irq_id_q     <= '0;
      last_grant_q <= IDW'(N - 1);
    end else begin
      state_q      <= state_d;
      irq_valid_q  <= irq_valid_d;
      irq_id_q     <= irq_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_valid_d  = irq_valid_q;
    irq_id_d     = irq_id_q;
    last_grant_d = last_grant_q;
    if (clr_all) begin
      state_d     = ST_IDLE;
      irq_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          irq_valid_d = 1'b0;
          if (found) begin
            irq_id_d    = sel;
            irq_valid_d = 1'b1;
            state_d     = ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (irq_ack) begin
            last_grant_d = irq_id_q;
            irq_valid_d  = 1'b0;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          irq_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_edge_irq_arbiter.sv
// Bench for edge_irq_arbiter: expected grant ids are queued as stimulus is driven
// and popped by a monitor at each new grant; flag state is checked inline.
module tb_edge_irq_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   irq_in = '0;
  logic [2*N-1:0] mode_cfg = 8'b01010101;
  logic           clr_all = 1'b0;
  logic           irq_ack = 1'b0;
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;

  int unsigned exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        valid_prev = 1'b0;

  edge_irq_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mode_cfg  (mode_cfg),
    .clr_all   (clr_all),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant monitor: every rising irq_valid must match the next queued id
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev <= 1'b0;
    end else begin
      if (irq_valid && !valid_prev) begin
        if (exp_q.size() == 0) check("grant_spurious", 32'(irq_id), 32'hFFFF_FFFF);
        else                   check("grant_id", 32'(irq_id), exp_q.pop_front());
      end
      valid_prev <= irq_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!irq_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 32'(irq_valid), 1);
  endtask

  task automatic serve(input int hold);
    wait_valid(20);
    tick(hold);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    check("rst_valid",   32'(irq_valid), 0);
    check("rst_id",      32'(irq_id), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    tick(2);

    // Single rising event on channel 2
    irq_in[2] = 1'b1;
    exp_q.push_back(2);
    tick(3);
    check("t1_pending", 32'(pending), 'h4);
    check("t1_valid_early", 32'(irq_valid), 0);
    tick(1);
    check("t1_valid", 32'(irq_valid), 1);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t1_pending_clr", 32'(pending), 0);
    check("t1_valid_clr", 32'(irq_valid), 0);
    irq_in[2] = 1'b0;
    tick(6);
    check("t1_no_regrant", 32'(irq_valid), 0);

    // Mode selectivity on channel 1: falling only
    mode_cfg = 8'b01011001;
    irq_in[1] = 1'b1;
    tick(4);
    check("t2_fall_ignores_rise", 32'(pending), 0);
    irq_in[1] = 1'b0;
    exp_q.push_back(1);
    tick(3);
    check("t2_fall_pending", 32'(pending), 'h2);
    serve(0);
    check("t2_fall_cleared", 32'(pending), 0);
    // Both edges
    mode_cfg = 8'b01011101;
    exp_q.push_back(1);
    irq_in[1] = 1'b1;
    serve(0);
    exp_q.push_back(1);
    irq_in[1] = 1'b0;
    serve(0);
    tick(2);
    // Disabled
    mode_cfg = 8'b01010001;
    irq_in[1] = 1'b1;
    tick(4);
    irq_in[1] = 1'b0;
    tick(6);
    check("t2_disabled_pending", 32'(pending), 0);
    check("t2_disabled_valid", 32'(irq_valid), 0);
    check("t2_overrun", 32'(overrun), 0);

    // Round-robin fairness
    do_reset();
    mode_cfg = 8'b01010101;
    tick(2);
    irq_in = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    tick(3);
    check("t3_pending", 32'(pending), 'hB);
    serve(2);
    serve(2);
    serve(2);
    irq_in = 4'b0000;
    tick(4);
    irq_in = 4'b1001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    serve(1);
    serve(1);
    irq_in = 4'b0000;
    tick(4);
    check("t3_pending_end", 32'(pending), 0);

    // Overrun on double edge of channel 0
    mode_cfg = 8'b01010111;
    irq_in[0] = 1'b1;
    exp_q.push_back(0);
    tick(3);
    irq_in[0] = 1'b0;
    tick(4);
    check("t4_overrun", 32'(overrun), 'h1);
    check("t4_pending", 32'(pending), 'h1);
    serve(0);
    check("t4_pending_clr", 32'(pending), 0);
    check("t4_overrun_sticky", 32'(overrun), 'h1);
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 0);

    // Event landing in the ack cycle of the same channel
    irq_in[0] = 1'b1;
    exp_q.push_back(0);
    wait_valid(20);
    irq_in[0] = 1'b0;
    exp_q.push_back(0);
    tick(2);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t4_collide_pending", 32'(pending), 'h1);
    check("t4_collide_valid", 32'(irq_valid), 0);
    check("t4_collide_overrun", 32'(overrun), 0);
    serve(0);
    check("t4_regrant_clr", 32'(pending), 0);

    // clr_all together with ack during a grant
    mode_cfg = 8'b11010101;
    irq_in = 4'b1010;
    exp_q.push_back(1);
    tick(3);
    irq_in[3] = 1'b0;
    tick(4);
    check("t5_pending", 32'(pending), 'hA);
    check("t5_overrun", 32'(overrun), 'h8);
    check("t5_valid", 32'(irq_valid), 1);
    clr_all = 1'b1;
    irq_ack = 1'b1;
    tick(1);
    clr_all = 1'b0;
    irq_ack = 1'b0;
    check("t5_clr_pending", 32'(pending), 0);
    check("t5_clr_overrun", 32'(overrun), 0);
    check("t5_clr_valid", 32'(irq_valid), 0);
    tick(6);
    check("t5_no_grant", 32'(irq_valid), 0);
    irq_in[1] = 1'b0;
    tick(4);

    // Async reset mid-grant, inputs held high through release
    mode_cfg = 8'b01010101;
    irq_in = 4'b0101;
    exp_q.push_back(2);
    wait_valid(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(irq_valid), 0);
    check("t6_async_id", 32'(irq_id), 0);
    check("t6_async_pending", 32'(pending), 0);
    check("t6_async_overrun", 32'(overrun), 0);
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(2);
    tick(3);
    check("t6_rel_pending", 32'(pending), 'h5);
    tick(1);
    check("t6_rel_valid", 32'(irq_valid), 1);
    serve(0);
    serve(0);
    irq_in = 4'b0000;
    tick(6);
    check("end_queue_empty", 32'(exp_q.size()), 0);
    check("end_valid", 32'(irq_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
